// File: rtl/axi_lite_regfile_if.sv
// AXI-Lite channel bundle: five handshaked channels with master and slave views.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    logic                    aw_valid;
    logic                    aw_ready;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]              aw_prot;
    logic                    w_valid;
    logic                    w_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    b_valid;
    logic                    b_ready;
    logic [1:0]              b_resp;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]              ar_prot;
    logic                    r_valid;
    logic                    r_ready;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input r_valid, r_data, r_resp, output r_ready
    );

    modport slave (
        input aw_valid, aw_addr, aw_prot, output aw_ready,
        input w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register bank: byte-strobed writes through one-entry AW/W holding
// registers, registered reads, read-only slots sourced from ro_value.
module axi_lite_regfile #(
    parameter int                    ADDR_WIDTH  = 48,
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    NUM_REGS    = 16,
    parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    axi_lite_channel.slave                 bus,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_value,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int HI     = LSB + 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [255:0] RO_MASK_EXT = 256'(RO_MASK);

    if (!(DATA_WIDTH == 32 || DATA_WIDTH == 64)) begin : g_bad_data_width
        $fatal(1, "axi_lite_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1 || NUM_REGS > 256) begin : g_bad_num_regs
        $fatal(1, "axi_lite_regfile: NUM_REGS must be 1..256");
    end
    if (ADDR_WIDTH < HI) begin : g_bad_addr_width
        $fatal(1, "axi_lite_regfile: ADDR_WIDTH too small for index decode");
    end

    logic                  aw_full_reg, w_full_reg, b_valid_reg, r_valid_reg;
    logic [ADDR_WIDTH-1:0] aw_addr_reg;
    logic [DATA_WIDTH-1:0] w_data_reg, r_data_reg, rd_val;
    logic [STRB_W-1:0]     w_strb_reg;
    logic [1:0]            b_resp_reg, r_resp_reg;
    logic [NUM_REGS-1:0]   wr_pulse_reg;
    logic [DATA_WIDTH-1:0] rd_word [NUM_REGS];
    logic                  commit, wr_in_range, wr_ro, wr_ok, rd_in_range, ar_fire;
    logic [7:0]            wr_idx, rd_idx;
    logic                  unused_ok;

    // Index must fit the bank and every bit above the 8-bit index field must be zero.
    function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
        return ({1'b0, a[LSB +: 8]} < 9'(NUM_REGS)) && ((a >> HI) == '0);
    endfunction

    assign bus.aw_ready = rstn & ~aw_full_reg;
    assign bus.w_ready  = rstn & ~w_full_reg;
    assign bus.ar_ready = rstn & ~r_valid_reg;
    assign bus.b_valid  = b_valid_reg;
    assign bus.b_resp   = b_resp_reg;
    assign bus.r_valid  = r_valid_reg;
    assign bus.r_data   = r_data_reg;
    assign bus.r_resp   = r_resp_reg;
    assign wr_pulse     = wr_pulse_reg;

    assign commit      = aw_full_reg & w_full_reg & ~b_valid_reg;
    assign wr_idx      = aw_addr_reg[LSB +: 8];
    assign wr_in_range = addr_in_range(aw_addr_reg);
    assign wr_ro       = RO_MASK_EXT[wr_idx];
    assign wr_ok       = commit & wr_in_range & ~wr_ro;
    assign rd_idx      = bus.ar_addr[LSB +: 8];
    assign rd_in_range = addr_in_range(bus.ar_addr);
    assign ar_fire     = bus.ar_valid & bus.ar_ready;
    assign unused_ok   = ^{bus.aw_prot, bus.ar_prot, aw_addr_reg[LSB-1:0],
                           bus.ar_addr[LSB-1:0], ro_value};

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        if (RO_MASK[gi]) begin : g_ro
            assign rd_word[gi] = ro_value[gi*DATA_WIDTH +: DATA_WIDTH];
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = '0;
        end else begin : g_rw
            logic [DATA_WIDTH-1:0] word_reg;
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    word_reg <= RESET_VALUE;
                end else if (wr_ok && wr_idx == 8'(gi)) begin
                    for (int b = 0; b < STRB_W; b++) begin
                        if (w_strb_reg[b]) word_reg[b*8 +: 8] <= w_data_reg[b*8 +: 8];
                    end
                end
            end
            assign rd_word[gi] = word_reg;
            assign reg_q[gi*DATA_WIDTH +: DATA_WIDTH] = word_reg;
        end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 8'(i)) rd_val = rd_word[i];
        end
    end

    // Holding registers cannot accept while both are full, so commit and accept never overlap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            aw_full_reg  <= 1'b0;
            w_full_reg   <= 1'b0;
            b_valid_reg  <= 1'b0;
            b_resp_reg   <= RESP_OKAY;
            wr_pulse_reg <= '0;
        end else begin
            wr_pulse_reg <= wr_ok ? (NUM_REGS'(1) << wr_idx) : '0;
            if (commit) begin
                aw_full_reg <= 1'b0;
                w_full_reg  <= 1'b0;
                b_valid_reg <= 1'b1;
                b_resp_reg  <= !wr_in_range ? RESP_DECERR : (wr_ro ? RESP_SLVERR : RESP_OKAY);
            end else begin
                if (bus.aw_valid && bus.aw_ready) aw_full_reg <= 1'b1;
                if (bus.w_valid && bus.w_ready)   w_full_reg  <= 1'b1;
                if (b_valid_reg && bus.b_ready)   b_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.aw_valid && bus.aw_ready) aw_addr_reg <= bus.aw_addr;
        if (bus.w_valid && bus.w_ready) begin
            w_data_reg <= bus.w_data;
            w_strb_reg <= bus.w_strb;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_valid_reg <= 1'b0;
            r_data_reg  <= '0;
            r_resp_reg  <= RESP_OKAY;
        end else if (ar_fire) begin
            r_valid_reg <= 1'b1;
            r_data_reg  <= rd_in_range ? rd_val : '0;
            r_resp_reg  <= rd_in_range ? RESP_OKAY : RESP_DECERR;
        end else if (r_valid_reg && bus.r_ready) begin
            r_valid_reg <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench: stimulus pushes expected B/R responses into queues, a monitor pops on each handshake.
module tb_axi_lite_regfile;
    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    logic         clk;
    logic         rstn;
    logic [127:0] ro_value;
    logic [127:0] reg_q;
    logic [3:0]   wr_pulse;
    logic [127:0] exp_q;
    int           pass_cnt;
    int           total_cnt;
    logic [1:0]   b_exp_q[$];
    r_exp_t       r_exp_q[$];

    axi_lite_channel #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(4),
        .RO_MASK(4'b1000), .RESET_VALUE(32'h0)
    ) dut (
        .clk(clk), .rstn(rstn), .bus(bus_if),
        .ro_value(ro_value), .reg_q(reg_q), .wr_pulse(wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic timeout(input string name);
        total_cnt++;
        $display("FAIL %s: got no handshake expected one within 50 cycles", name);
    endtask

    task automatic send_aw(input logic [31:0] a);
        bit ok = 0;
        bus_if.aw_addr = a;
        bus_if.aw_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_if.aw_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("aw_handshake");
        @(posedge clk); #1;
        bus_if.aw_valid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        bit ok = 0;
        bus_if.w_data = d;
        bus_if.w_strb = s;
        bus_if.w_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_if.w_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("w_handshake");
        @(posedge clk); #1;
        bus_if.w_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        bit ok = 0;
        bus_if.ar_addr = a;
        bus_if.ar_valid = 1'b1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (bus_if.ar_ready) begin ok = 1; break; end
        end
        if (!ok) timeout("ar_handshake");
        @(posedge clk); #1;
        bus_if.ar_valid = 1'b0;
    endtask

    task automatic write_both(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        fork
            send_aw(a);
            send_w(d, s);
        join
    endtask

    always @(negedge clk) begin
        if (rstn && bus_if.b_valid && bus_if.b_ready) begin
            if (b_exp_q.size() == 0) begin
                check("b_unexpected", 128'(bus_if.b_valid), 128'(0));
            end else begin
                logic [1:0] e;
                e = b_exp_q.pop_front();
                $display("B  resp=%0d expected=%0d", bus_if.b_resp, e);
                check("b_resp", 128'(bus_if.b_resp), 128'(e));
            end
        end
        if (rstn && bus_if.r_valid && bus_if.r_ready) begin
            if (r_exp_q.size() == 0) begin
                check("r_unexpected", 128'(bus_if.r_valid), 128'(0));
            end else begin
                r_exp_t e;
                e = r_exp_q.pop_front();
                $display("R  data=%h resp=%0d expected data=%h resp=%0d",
                         bus_if.r_data, bus_if.r_resp, e.data, e.resp);
                check("r_data", 128'(bus_if.r_data), 128'(e.data));
                check("r_resp", 128'(bus_if.r_resp), 128'(e.resp));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected $finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rstn = 1'b0;
        ro_value = '0;
        exp_q = '0;
        bus_if.aw_valid = 0; bus_if.aw_addr = '0; bus_if.aw_prot = '0;
        bus_if.w_valid = 0;  bus_if.w_data = '0;  bus_if.w_strb = '0;
        bus_if.ar_valid = 0; bus_if.ar_addr = '0; bus_if.ar_prot = '0;
        bus_if.b_ready = 1;  bus_if.r_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_aw_ready", 128'(bus_if.aw_ready), 128'(0));
        check("rst_w_ready", 128'(bus_if.w_ready), 128'(0));
        check("rst_ar_ready", 128'(bus_if.ar_ready), 128'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        check("post_rst_b_valid", 128'(bus_if.b_valid), 128'(0));
        check("post_rst_r_valid", 128'(bus_if.r_valid), 128'(0));
        check("post_rst_reg_q", reg_q, exp_q);
        check("post_rst_wr_pulse", 128'(wr_pulse), 128'(0));
        check("post_rst_aw_ready", 128'(bus_if.aw_ready), 128'(1));
        check("post_rst_ar_ready", 128'(bus_if.ar_ready), 128'(1));
        @(posedge clk); #1;

        // Read after reset: one-cycle latency, zero data
        r_exp_q.push_back('{data: 32'h0, resp: 2'b00});
        send_ar(32'h4);
        check("r_latency", 128'(bus_if.r_valid), 128'(1));
        @(posedge clk); #1;

        // Same-cycle AW/W with partial strobes
        b_exp_q.push_back(2'b00);
        write_both(32'h8, 32'hDEADBEEF, 4'b0101);
        @(posedge clk); #1;
        exp_q[95:64] = 32'h00AD00EF;
        check("t2_b_valid", 128'(bus_if.b_valid), 128'(1));
        check("t2_wr_pulse", 128'(wr_pulse), 128'(4'b0100));
        check("t2_reg_q", reg_q, exp_q);
        @(posedge clk); #1;
        check("t2_wr_pulse_clear", 128'(wr_pulse), 128'(0));
        r_exp_q.push_back('{data: 32'h00AD00EF, resp: 2'b00});
        send_ar(32'h8);
        r_exp_q.push_back('{data: 32'h00AD00EF, resp: 2'b00});
        send_ar(32'h9);
        @(posedge clk); #1;

        // W ahead of AW, B stalled while a second write waits in the holding registers
        bus_if.b_ready = 1'b0;
        b_exp_q.push_back(2'b00);
        send_w(32'h12345678, 4'hF);
        check("t3_w_ready_held", 128'(bus_if.w_ready), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        send_aw(32'h0);
        @(posedge clk); #1;
        exp_q[31:0] = 32'h12345678;
        check("t3_b_valid", 128'(bus_if.b_valid), 128'(1));
        check("t3_reg_q", reg_q, exp_q);
        check("t3_wr_pulse", 128'(wr_pulse), 128'(4'b0001));
        b_exp_q.push_back(2'b00);
        write_both(32'h4, 32'h0BADCAFE, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t3_stall_b_valid", 128'(bus_if.b_valid), 128'(1));
            check("t3_stall_aw_ready", 128'(bus_if.aw_ready), 128'(0));
            check("t3_stall_w_ready", 128'(bus_if.w_ready), 128'(0));
            check("t3_stall_reg_q", reg_q, exp_q);
        end
        bus_if.b_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_b_drop", 128'(bus_if.b_valid), 128'(0));
        @(posedge clk); #1;
        exp_q[63:32] = 32'h0BADCAFE;
        check("t3_second_commit", 128'(bus_if.b_valid), 128'(1));
        check("t3_second_reg_q", reg_q, exp_q);
        check("t3_second_pulse", 128'(wr_pulse), 128'(4'b0010));
        @(posedge clk); #1;

        // Read-only register: SLVERR on write, ro_value on read
        ro_value[127:96] = 32'hCAFEF00D;
        b_exp_q.push_back(2'b10);
        write_both(32'hC, 32'h11111111, 4'hF);
        @(posedge clk); #1;
        check("t4_reg_q", reg_q, exp_q);
        check("t4_wr_pulse", 128'(wr_pulse), 128'(0));
        r_exp_q.push_back('{data: 32'hCAFEF00D, resp: 2'b00});
        send_ar(32'hC);
        @(posedge clk); #1;

        // Out-of-range accesses, including an index alias with a high address bit set
        r_exp_q.push_back('{data: 32'h0, resp: 2'b11});
        send_ar(32'h10);
        r_exp_q.push_back('{data: 32'h0, resp: 2'b11});
        send_ar(32'h402);
        b_exp_q.push_back(2'b11);
        write_both(32'h40, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        check("t5_reg_q", reg_q, exp_q);
        check("t5_wr_pulse", 128'(wr_pulse), 128'(0));
        @(posedge clk); #1;
        b_exp_q.push_back(2'b11);
        write_both(32'h400, 32'hFFFFFFFF, 4'hF);
        @(posedge clk); #1;
        check("t5_alias_reg_q", reg_q, exp_q);
        @(posedge clk); #1;

        // Reset between AW and W drops the write
        send_aw(32'h4);
        @(posedge clk); #1;
        rstn = 1'b0;
        @(negedge clk);
        check("t6_rst_aw_ready", 128'(bus_if.aw_ready), 128'(0));
        check("t6_rst_w_ready", 128'(bus_if.w_ready), 128'(0));
        check("t6_rst_ar_ready", 128'(bus_if.ar_ready), 128'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_q = '0;
        check("t6_reg_q", reg_q, exp_q);
        send_w(32'hA5A5A5A5, 4'hF);
        repeat (3) begin
            @(posedge clk); #1;
            check("t6_no_b", 128'(bus_if.b_valid), 128'(0));
        end
        b_exp_q.push_back(2'b00);
        send_aw(32'h4);
        @(posedge clk); #1;
        exp_q[63:32] = 32'hA5A5A5A5;
        check("t6_new_reg_q", reg_q, exp_q);
        check("t6_new_pulse", 128'(wr_pulse), 128'(4'b0010));

        repeat (5) @(posedge clk);
        #1;
        check("b_queue_drained", 128'(b_exp_q.size()), 128'(0));
        check("r_queue_drained", 128'(r_exp_q.size()), 128'(0));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
